// File: rtl/word_fifo.sv
// word_fifo: DEPTH-entry, WIDTH-bit synchronous FIFO with valid/ready on both sides.
// Latency: a word pushed into an empty FIFO is presented on out_data the cycle after the push edge.
// Backpressure: in_ready drops when full (no pass-through); out_valid drops when empty.
//
// Ports:
//   clk, rst_n            - single clock (rising edge), asynchronous active-low reset
//   in_data/in_valid/in_ready    - producer side; push when in_valid && in_ready
//   out_data/out_valid/out_ready - consumer side; pop when out_valid && out_ready
//   count (optional)      - registered occupancy, present only when WORD_FIFO_COUNT_EN is defined
//
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.

module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef WORD_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    logic push;
    logic pop;

    // Both handshake outputs come from the occupancy register only, so there
    // is no combinational path from out_ready to in_ready or in_valid to out_valid.
    assign in_ready  = (occ_q != FULL_CNT);
    assign out_valid = (occ_q != '0);

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    // Gate the head word so stale storage (never cleared by reset) cannot leak out.
    assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef WORD_FIFO_COUNT_EN
    assign count = occ_q;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // push is impossible when full and pop impossible when empty, so the
        // counter stays within 0..DEPTH without explicit saturation.
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately not reset; visibility is controlled by occupancy.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/word_fifo.md
WORD_FIFO -- requirements
Module: word_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: the word offered by the producer.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the producer is offering in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: the head word, which drives the downstream Not array input directly.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid head word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head word this cycle.

Function
REQ-011 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-012 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; the read pointer increments modulo DEPTH.
REQ-013 in_ready SHALL be 1 exactly when occupancy < DEPTH; it is derived from registered state only, with no combinational path from out_ready.
REQ-014 out_valid SHALL be 1 exactly when occupancy > 0; it is derived from registered state only, with no path from in_valid.
REQ-015 out_data SHALL equal the entry at the read pointer when out_valid=1, and SHALL be all zeros when the FIFO is empty.
REQ-016 Latency: a word pushed into an empty FIFO SHALL appear on out_data, with out_valid=1, in the cycle after the push edge; there is no same-cycle bypass.
REQ-017 Simultaneous push and pop when 0 < occupancy < DEPTH SHALL leave occupancy unchanged, and both pointers advance.
REQ-018 When full, in_ready=0 and in_valid SHALL be ignored, even if a pop occurs in the same cycle; no pass-through when full.
REQ-019 When empty, out_ready SHALL be ignored; pointers and occupancy remain unchanged.
REQ-020 Occupancy SHALL be a counter of width clog2(DEPTH)+1 ranging 0..DEPTH, and SHALL never wrap.
REQ-021 Words SHALL leave in exact push order, with no loss or duplication across pointer wrap-around.
REQ-022 in_data SHALL be sampled only on a push edge; changes to it while in_ready=0 have no effect.

Reset
REQ-023 When rst_n=0, reset SHALL take effect immediately, independent of clk.
REQ-024 Reset SHALL clear both pointers and occupancy to 0, giving out_valid=0, in_ready=1 and out_data=0.
REQ-025 Storage contents need not be cleared on reset, but they SHALL never be visible on out_data after reset until they are rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first push after reset deassertion SHALL become the head.
REQ-027 Reset SHALL deassert synchronously to clk externally; no push or pop is honoured on the edge where rst_n is low.

Configuration
REQ-028 When macro WORD_FIFO_COUNT_EN is defined, the block SHALL add an output port count, of width clog2(DEPTH)+1, equal to the registered occupancy, with reset value 0.
REQ-029 When WORD_FIFO_COUNT_EN is undefined, the count port and any logic used only by it SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset check: hold rst_n=0 and toggle inputs -> out_valid=0, in_ready=1, out_data=16'h0000, count=0.
REQ-031 Fill and drain: push 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3 with out_ready=0 -> in_ready=0 after the 4th push, count=4; then set out_ready=1 -> outputs appear in the same order, and the Not16 output reads 16'hFFFF, 16'h0000, 16'h5555, 16'hC33C.
REQ-032 Full with push and pop: when full, drive in_valid=1 with 16'h1234 and out_ready=1 -> one pop only, count=3, and 16'h1234 is not stored.
REQ-033 Empty pop: with the FIFO empty, out_ready=1 for 3 cycles -> pointers unchanged, out_valid=0, out_data=0.
REQ-034 Wrap-around streaming: continuous in_valid=1 and out_ready=1 for 20 words 16'h0001..16'h0014 -> steady occupancy of 1, and all 20 words are output in order.
REQ-035 Mid-operation reset: push 16'h0ABC and 16'h0DEF, pulse rst_n=0 between clock edges -> outputs clear immediately; then push 16'h0042 -> head is 16'h0042 one cycle later.
